// File: rtl/rst_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rst_seq_ctrl_pkg
// Purpose : Shared definitions for the board reset sequencer: state codes,
//           lock-loss counter width and a saturating increment helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package rst_seq_ctrl_pkg;

  // State codes are visible on the `state` output, so the encoding is fixed.
  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  localparam int unsigned c_loss_cnt_w = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [c_loss_cnt_w-1:0] sat_inc(
    input logic [c_loss_cnt_w-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_ctrl_sync_chain.sv
`default_nettype none
// ============================================================================
// Module  : sync_chain
// Purpose : N-stage flop synchroniser with asynchronous active-low clear.
//           The output is the last stage; a new input value appears after
//           STAGES rising edges.
// Ports   : clk   - sampling clock
//           rst_n - asynchronous active-low clear of every stage
//           d_i   - asynchronous input
//           q_o   - synchronised output
// Rev     : 1.0  initial release
// ============================================================================
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rst_seq_ctrl
// Purpose : Board reset sequencer. Synchronises the reset pin and PLL lock,
//           filters lock, waits a hold time, then releases NUM_OUT
//           active-high resets one after another in index order. Any lock
//           loss or a software request while running returns to RESET.
// Ports   : clk           - PLL output clock
//           reset_n       - board reset pin, async assert / sync deassert
//           pll_locked    - PLL lock, asynchronous to clk
//           soft_req      - one-cycle request to re-run the sequence
//           reset_out     - registered active-high resets
//           ready         - high while in RUN
//           state         - current state code
//           lock_loss_cnt - saturating count of lock losses seen in RUN
// Rev     : 1.0  initial release
// ============================================================================
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOCK_FILTER    = 8,
  parameter int unsigned HOLD_CYCLES    = 1024,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned NUM_OUT        = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_locked,
  input  logic                    soft_req,
  output logic [NUM_OUT-1:0]      reset_out,
  output logic                    ready,
  output logic [1:0]              state,
  output logic [c_loss_cnt_w-1:0] lock_loss_cnt
);

  logic w_rst_rel;   // high once the internal reset has been released
  logic w_lock_sync; // synchronised PLL lock

  sync_chain #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (1'b1),
    .q_o   (w_rst_rel)
  );

  sync_chain #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (pll_locked),
    .q_o   (w_lock_sync)
  );

  seq_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [NUM_OUT-1:0]      reset_out_q, reset_out_d;
  logic                    ready_q, ready_d;
  logic [c_loss_cnt_w-1:0] loss_q, loss_d;

  logic [CNT_WIDTH-1:0]    w_cnt_inc;
  logic [NUM_OUT-1:0]      w_rel_next;

  assign w_cnt_inc  = cnt_q + CNT_WIDTH'(1);
  // Outputs release in index order, so shifting a zero in from the LSB
  // clears the next index; all-zero means the last output just released.
  assign w_rel_next = reset_out_q << 1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reset_out_d = reset_out_q;
    loss_d      = loss_q;

    unique case (state_q)
      ST_RESET: begin
        reset_out_d = '1;
        if (!w_lock_sync) begin
          cnt_d = '0;
        end else if (w_cnt_inc == CNT_WIDTH'(LOCK_FILTER)) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      ST_HOLD: begin
        if (!w_lock_sync) begin
          cnt_d   = '0;
          state_d = ST_RESET;
        end else if (w_cnt_inc == CNT_WIDTH'(HOLD_CYCLES)) begin
          cnt_d       = '0;
          reset_out_d = w_rel_next;
          // With a single output the first release is also the last.
          state_d     = (w_rel_next == '0) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      ST_RELEASE: begin
        if (!w_lock_sync) begin
          cnt_d       = '0;
          reset_out_d = '1;
          state_d     = ST_RESET;
        end else if (w_cnt_inc == CNT_WIDTH'(STAGGER_CYCLES)) begin
          cnt_d       = '0;
          reset_out_d = w_rel_next;
          state_d     = (w_rel_next == '0) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      ST_RUN: begin
        cnt_d = '0;
        // Lock loss is checked first so a coincident soft request still
        // gets the loss counted.
        if (!w_lock_sync) begin
          reset_out_d = '1;
          loss_d      = sat_inc(loss_q);
          state_d     = ST_RESET;
        end else if (soft_req) begin
          reset_out_d = '1;
          state_d     = ST_RESET;
        end
      end

      default: begin
        cnt_d       = '0;
        reset_out_d = '1;
        state_d     = ST_RESET;
      end
    endcase

    ready_d = (state_d == ST_RUN);
  end

  // The pin clears everything asynchronously; until the reset synchroniser
  // releases, the sequencer is held in its reset values synchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      reset_out_q <= '1;
      ready_q     <= 1'b0;
      loss_q      <= '0;
    end else if (!w_rst_rel) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      reset_out_q <= '1;
      ready_q     <= 1'b0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reset_out_q <= reset_out_d;
      ready_q     <= ready_d;
      loss_q      <= loss_d;
    end
  end

  assign reset_out     = reset_out_q;
  assign ready         = ready_q;
  assign state         = state_q;
  assign lock_loss_cnt = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rst_seq_ctrl
// Purpose : Directed self-checking bench for rst_seq_ctrl. Instance u_dut
//           uses a 3-output configuration; u_dut1 uses a single output with
//           a one-cycle hold.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rst_seq_ctrl;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_req   = 1'b0;

  logic [2:0] rst_out_a;
  logic       ready_a;
  logic [1:0] state_a;
  logic [7:0] loss_a;

  logic [0:0] rst_out_b;
  logic       ready_b;
  logic [1:0] state_b;
  logic [7:0] loss_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .SYNC_STAGES(2), .LOCK_FILTER(4), .HOLD_CYCLES(8),
    .STAGGER_CYCLES(3), .NUM_OUT(3), .CNT_WIDTH(16)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .soft_req(soft_req),
    .reset_out(rst_out_a), .ready(ready_a), .state(state_a), .lock_loss_cnt(loss_a)
  );

  rst_seq_ctrl #(
    .SYNC_STAGES(2), .LOCK_FILTER(4), .HOLD_CYCLES(1),
    .STAGGER_CYCLES(3), .NUM_OUT(1), .CNT_WIDTH(16)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .soft_req(soft_req),
    .reset_out(rst_out_b), .ready(ready_b), .state(state_b), .lock_loss_cnt(loss_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected 3-output sequence after edge e, when HOLD is entered on edge h:
  // RELEASE at h+8 (110), next release at h+11 (100), RUN at h+14 (000).
  task automatic check_seq(input string tag, input int e, input int h);
    logic [1:0] es;
    logic [2:0] er;
    logic       ey;
    if (e < h)            begin es = 2'd0; er = 3'b111; ey = 1'b0; end
    else if (e < h + 8)   begin es = 2'd1; er = 3'b111; ey = 1'b0; end
    else if (e < h + 11)  begin es = 2'd2; er = 3'b110; ey = 1'b0; end
    else if (e < h + 14)  begin es = 2'd2; er = 3'b100; ey = 1'b0; end
    else                  begin es = 2'd3; er = 3'b000; ey = 1'b1; end
    check_val($sformatf("%s_e%0d_state", tag, e), 32'(state_a), 32'(es));
    check_val($sformatf("%s_e%0d_rst", tag, e), 32'(rst_out_a), 32'(er));
    check_val($sformatf("%s_e%0d_ready", tag, e), 32'(ready_a), 32'(ey));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    check_val("rst_async_out",   32'(rst_out_a), 32'h7);
    check_val("rst_async_ready", 32'(ready_a),   32'h0);
    check_val("rst_async_state", 32'(state_a),   32'h0);
    check_val("rst_async_loss",  32'(loss_a),    32'h0);
    check_val("rst_async_out1",  32'(rst_out_b), 32'h1);

    tick(); tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check_val("rst_rel_state", 32'(state_a),   32'h0);
    check_val("rst_rel_out",   32'(rst_out_a), 32'h7);

    // Clean bring-up, both configurations.
    pll_locked = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      logic [1:0] es1;
      tick();
      check_seq("clean", e, 6);
      es1 = (e < 6) ? 2'd0 : ((e == 6) ? 2'd1 : 2'd3);
      check_val($sformatf("one_e%0d_state", e), 32'(state_b), 32'(es1));
      check_val($sformatf("one_e%0d_rst", e), 32'(rst_out_b), (e < 7) ? 32'h1 : 32'h0);
      check_val($sformatf("one_e%0d_ready", e), 32'(ready_b), (e < 7) ? 32'h0 : 32'h1);
    end
    check_val("clean_loss", 32'(loss_a), 32'h0);

    // Soft request in RUN: RESET next edge, no count; lock still high so the
    // filter restarts from zero and reaches HOLD four edges later.
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    check_val("soft_state", 32'(state_a),   32'h0);
    check_val("soft_rst",   32'(rst_out_a), 32'h7);
    check_val("soft_ready", 32'(ready_a),   32'h0);
    check_val("soft_loss",  32'(loss_a),    32'h0);
    repeat (3) tick();
    check_val("soft_refilt3", 32'(state_a), 32'h0);
    tick();
    check_val("soft_refilt4", 32'(state_a), 32'h1);

    // Lock loss in HOLD returns to RESET without counting.
    pll_locked = 1'b0;
    repeat (5) tick();
    check_val("hold_loss_state", 32'(state_a),   32'h0);
    check_val("hold_loss_rst",   32'(rst_out_a), 32'h7);
    check_val("hold_loss_cnt",   32'(loss_a),    32'h0);

    // Soft request during HOLD must not disturb the timing.
    for (int e = 1; e <= 20; e++) begin
      pll_locked = 1'b1;
      soft_req   = (e == 9);
      tick();
      soft_req   = 1'b0;
      check_seq("softhold", e, 6);
    end

    // Lock loss in RUN: reaction on the third edge after the fall.
    pll_locked = 1'b0;
    tick();
    check_val("loss_e1_state", 32'(state_a), 32'h3);
    tick();
    check_val("loss_e2_ready", 32'(ready_a), 32'h1);
    tick();
    check_val("loss_e3_state", 32'(state_a),   32'h0);
    check_val("loss_e3_rst",   32'(rst_out_a), 32'h7);
    check_val("loss_e3_ready", 32'(ready_a),   32'h0);
    check_val("loss_e3_cnt",   32'(loss_a),    32'h1);

    // Lock chatter: high 3, low 1, high; HOLD on edge 10.
    for (int e = 1; e <= 24; e++) begin
      pll_locked = (e != 4);
      tick();
      check_seq("chatter", e, 10);
    end

    // Lock loss coinciding with a soft request still counts.
    pll_locked = 1'b0;
    tick(); tick();
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    check_val("both_state", 32'(state_a), 32'h0);
    check_val("both_cnt",   32'(loss_a),  32'h2);

    // Repeated losses up to 300 in total: saturate at 255.
    for (int i = 3; i <= 300; i++) begin
      pll_locked = 1'b1;
      repeat (20) tick();
      if (i == 300) check_val("sat_run_state", 32'(state_a), 32'h3);
      pll_locked = 1'b0;
      repeat (3) tick();
      if (i == 254) check_val("sat_cnt_254", 32'(loss_a), 32'd254);
      if (i == 255) check_val("sat_cnt_255", 32'(loss_a), 32'd255);
      if (i == 256) check_val("sat_cnt_256", 32'(loss_a), 32'd255);
      if (i == 300) check_val("sat_cnt_300", 32'(loss_a), 32'd255);
    end

    // reset_n low mid-RELEASE forces all resets without a clock edge.
    pll_locked = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      check_seq("prerst", e, 6);
    end
    #2 reset_n = 1'b0;
    #1;
    check_val("midrel_rst",   32'(rst_out_a), 32'h7);
    check_val("midrel_state", 32'(state_a),   32'h0);
    check_val("midrel_ready", 32'(ready_a),   32'h0);
    check_val("midrel_loss",  32'(loss_a),    32'h0);
    reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check_seq("postrst", e, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Parametrised reset sequencer for board top levels, generalising the two-flop reset synchroniser used ahead of the SoC instance. It synchronises the board reset pin and PLL lock, waits for a filtered stable lock plus a hold time, then releases `NUM_OUT` active-high synchronous reset outputs in a staggered order. It re-enters reset on lock loss or on a software request. It sits between the PLL and the SoC/peripheral instances in every board top.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for `reset_n` deassertion and `pll_locked` (≥2)
- `LOCK_FILTER`, 8: consecutive synchronised-lock-high cycles required (≥1)
- `HOLD_CYCLES`, 1024: cycles in HOLD after the filter passes (≥1)
- `STAGGER_CYCLES`, 16: cycles between successive output releases (≥1)
- `NUM_OUT`, 2: number of reset outputs (≥1)
- `CNT_WIDTH`, 16: shared counter width; must hold `max(LOCK_FILTER, HOLD_CYCLES, STAGGER_CYCLES)`
- `clk` in 1: PLL output clock; single clock domain
- `reset_n` in 1: board reset pin; reset is asynchronous and active-low
- `pll_locked` in 1: PLL lock, asynchronous to `clk`
- `soft_req` in 1: synchronous one-cycle request to re-run the sequence
- `reset_out` out `NUM_OUT`: active-high synchronous resets, released in index order
- `ready` out 1: high in RUN
- `state` out 2: current state code
- `lock_loss_cnt` out 8: saturating count of lock losses seen in RUN

## Operation
- `reset_n` low: asynchronously force `reset_out` all ones, `ready`=0, `state`=RESET, counters 0, `lock_loss_cnt`=0, both synchroniser chains 0.
- `reset_n` rising: internal reset releases after `SYNC_STAGES` edges. This is assert-async, deassert-sync.
- States: RESET=0, HOLD=1, RELEASE=2, RUN=3.
- RESET: all outputs asserted.
  - Filter counter increments each cycle `lock_sync`=1 and clears to 0 when `lock_sync`=0.
  - The edge on which the counter reaches `LOCK_FILTER` enters HOLD and clears the counter.
- HOLD: counter increments each cycle. The edge on which it reaches `HOLD_CYCLES` enters RELEASE.
  - If `lock_sync`=0 in any cycle, return to RESET and clear the counter. No `lock_loss_cnt` increment.
- RELEASE:
  - The entering edge clears `reset_out[0]`.
  - Each later edge on which the stagger counter reaches `STAGGER_CYCLES` clears the next index and restarts the counter.
  - The edge that clears `reset_out[NUM_OUT-1]` also enters RUN.
  - If `NUM_OUT`=1, HOLD goes directly to RUN, and that edge clears `reset_out[0]`.
  - `lock_sync`=0 → RESET, with the same treatment as in HOLD.
- RUN: `ready`=1.
  - `lock_sync`=0 → RESET on the next edge. That edge sets all `reset_out`=1 and `ready`=0, and `lock_loss_cnt` increments, saturating at 255.
  - `soft_req`=1 → RESET on the next edge, no count change.
  - If both occur in the same cycle, the lock loss wins and the count increments.
- `soft_req` is ignored outside RUN.
- Released outputs never reassert except via a transition to RESET. All outputs reassert on the same edge.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- `pll_locked` → `lock_sync` latency: `SYNC_STAGES` edges.
- Minimum lock-to-first-release: `SYNC_STAGES` + `LOCK_FILTER` + `HOLD_CYCLES` edges.
- Release of index i: i·`STAGGER_CYCLES` edges after entering RELEASE.
- Lock-loss reaction in RUN: `SYNC_STAGES`+1 edges from `pll_locked` falling.
- A lock glitch shorter than one clock may be missed. This is accepted.

## Structure
- A shared package holds the state codes (RESET/HOLD/RELEASE/RUN) and the `lock_loss_cnt` width constant.
- Sub-module `sync_chain`: parametrised N-stage flop synchroniser with async active-low clear. It is instanced twice:
  - for reset deassertion, with input tied to 1;
  - for `pll_locked`.
- FSM and counters live in `rst_seq_ctrl`.

## Test plan
Parameters unless stated: `SYNC_STAGES`=2, `LOCK_FILTER`=4, `HOLD_CYCLES`=8, `STAGGER_CYCLES`=3, `NUM_OUT`=3. Edge counts are from the first edge sampling `pll_locked`=1, with internal reset already released.
- Clean bring-up: HOLD after edge 6; RELEASE after edge 14. `reset_out` goes 3'b110 after edge 14, 3'b100 after 17, 3'b000 after 20. `ready`=1 and `state`=3 after 20.
- Lock chatter: `pll_locked` high 3 cycles, low 1, then high → filter restarts; HOLD is entered 4 clean cycles later; `reset_out` stays 3'b111 throughout.
- Lock loss in RUN: `pll_locked` falls → `reset_out`=3'b111, `ready`=0 and `state`=0 exactly 3 edges later; `lock_loss_cnt` 0→1. Repeated 300 times → saturates at 255.
- `soft_req` pulse in RUN → RESET next edge with no count change. Pulse during HOLD → ignored, and sequence timing is unchanged.
- `reset_n` low mid-RELEASE (`reset_out`=3'b100) → 3'b111 immediately, without waiting for a clock edge. After `reset_n` rises, no release occurs before 2 edges plus the full sequence.
- `NUM_OUT`=1, `HOLD_CYCLES`=1: `reset_out[0]`=0 and `state`=3 on the same edge, after edge 7.
